// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and op classification.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    logic             busy;
    logic [SHW:0]     cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;

    // hi/lo is {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        sum  = '0;
        rsh  = '0;
        diff = '0;
        if (is_divide(op_q)) begin
            rsh  = {hi, lo[WIDTH-1]};
            diff = rsh - {1'b0, mcand};
            if (!diff[WIDTH]) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = rsh[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // Result is taken from the final step's next-state value so it is ready on the done cycle.
    always_comb begin
        done   = busy && (cnt == CNT_LAST);
        result = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_n : lo_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_MUL;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            hi    <= '0;
            mcand <= is_divide(op) ? b : a;
            lo    <= is_divide(op) ? a : b;
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + (SHW+1)'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops complete in one cycle,
// multiply/divide are delegated to the iterative unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_OP,
    input  logic [WIDTH-1:0] ALU_A,
    input  logic [WIDTH-1:0] ALU_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_F,
    output logic             ZF,
    output logic             CF,
    output logic             OF,
    output logic             SF
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             mc_op;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] sc_f;
    logic             sc_cf;
    logic             sc_of;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SHW-1:0]   shamt;

    assign accept = in_valid && in_ready;
    assign mc_op  = is_multicycle(ALU_OP);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && mc_op),
        .op     (ALU_OP),
        .a      (ALU_A),
        .b      (ALU_B),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = mc_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_n = mc_op ? BUSY : DONE;
                end else if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Single-cycle datapath; sub uses A + ~B + 1 so its carry-out is the inverted borrow.
    always_comb begin
        add_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
        sub_sum = {1'b0, ALU_A} + {1'b0, ~ALU_B} + (WIDTH+1)'(1);
        shamt   = ALU_B[SHW-1:0];
        sc_f    = '0;
        sc_cf   = 1'b0;
        sc_of   = 1'b0;
        case (ALU_OP)
            OP_ADD: begin
                sc_f  = add_sum[WIDTH-1:0];
                sc_cf = add_sum[WIDTH];
                sc_of = (ALU_A[WIDTH-1] == ALU_B[WIDTH-1]) && (add_sum[WIDTH-1] != ALU_A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_f  = sub_sum[WIDTH-1:0];
                sc_cf = ~sub_sum[WIDTH];
                sc_of = (ALU_A[WIDTH-1] != ALU_B[WIDTH-1]) && (sub_sum[WIDTH-1] != ALU_A[WIDTH-1]);
            end
            OP_SLL:  sc_f = ALU_A << shamt;
            OP_SRL:  sc_f = ALU_A >> shamt;
            OP_SRA:  sc_f = $signed(ALU_A) >>> shamt;
            OP_SLT:  sc_f = {{(WIDTH-1){1'b0}}, ($signed(ALU_A) < $signed(ALU_B))};
            OP_SLTU: sc_f = {{(WIDTH-1){1'b0}}, (ALU_A < ALU_B)};
            OP_XOR:  sc_f = ALU_A ^ ALU_B;
            OP_OR:   sc_f = ALU_A | ALU_B;
            OP_AND:  sc_f = ALU_A & ALU_B;
            default: sc_f = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_F <= '0;
            ZF    <= 1'b0;
            CF    <= 1'b0;
            OF    <= 1'b0;
            SF    <= 1'b0;
        end else if (accept && !mc_op) begin
            ALU_F <= sc_f;
            ZF    <= (sc_f == '0);
            CF    <= sc_cf;
            OF    <= sc_of;
            SF    <= sc_f[WIDTH-1];
        end else if (md_done) begin
            ALU_F <= md_result;
            ZF    <= (md_result == '0);
            CF    <= 1'b0;
            OF    <= 1'b0;
            SF    <= md_result[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven scoreboard bench for alu_seq plus hand-written multi-cycle corner sequences.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ALU_OP = '0;
    logic [W-1:0] ALU_A = '0;
    logic [W-1:0] ALU_B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] ALU_F;
    logic         ZF, CF, OF, SF;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic [3:0]   flg;  // {ZF,CF,OF,SF}
        int           lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
        bit   chk_lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    vec_t drv;
    bit   drv_chk_lat = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   accepted;
    bit   s_in_ready;
    bit   s_out_valid;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_OP    (ALU_OP),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_F     (ALU_F),
        .ZF        (ZF),
        .CF        (CF),
        .OF        (OF),
        .SF        (SF)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] f, input logic [3:0] flg);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.f   = f;
        v.flg = flg;
        v.lat = is_multicycle(op) ? int'(W) + 1 : 1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // One clock: sample at negedge (scoreboard pop, accept push), then return #1 after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        accepted    = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got F=0x%08h expected no output (cycle %0d)", ALU_F, cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("F op=%b", e.v.op), ALU_F, e.v.f);
                chk($sformatf("flags op=%b", e.v.op), 32'({ZF, CF, OF, SF}), 32'(e.v.flg));
                if (e.chk_lat) begin
                    chk($sformatf("latency op=%b", e.v.op), cyc - e.acc_cyc, e.v.lat);
                end
            end
        end
        if (in_valid && in_ready) begin
            e.v       = drv;
            e.acc_cyc = cyc;
            e.chk_lat = drv_chk_lat;
            sb.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input vec_t v);
        drv      = v;
        ALU_OP   = v.op;
        ALU_A    = v.a;
        ALU_B    = v.b;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) timeout_fail("accept_timeout");
        in_valid = 1'b0;
        ALU_OP   = 4'($urandom);
        ALU_A    = $urandom;
        ALU_B    = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            timeout_fail("drain_timeout");
            sb.delete();
        end
    endtask

    initial begin
        int busy_cnt;

        tbl.push_back(mk(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011));
        tbl.push_back(mk(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100));
        tbl.push_back(mk(OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0101));
        tbl.push_back(mk(OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 4'b1000));
        tbl.push_back(mk(OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010));
        tbl.push_back(mk(OP_SLL,   32'h00000001, 32'h00000024, 32'h00000010, 4'b0000));
        tbl.push_back(mk(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000));
        tbl.push_back(mk(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000));
        tbl.push_back(mk(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000));
        tbl.push_back(mk(OP_SRL,   32'h80000000, 32'h0000003F, 32'h00000001, 4'b0000));
        tbl.push_back(mk(OP_OR,    32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000));
        tbl.push_back(mk(OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000));
        tbl.push_back(mk(OP_SRA,   32'h80000000, 32'h00000004, 32'hF8000000, 4'b0001));
        tbl.push_back(mk(OP_SRA,   32'h40000000, 32'h00000021, 32'h20000000, 4'b0000));
        tbl.push_back(mk(4'b1110,  32'h00000005, 32'h00000003, 32'h00000000, 4'b1000));
        tbl.push_back(mk(4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000));
        tbl.push_back(mk(OP_MUL,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0001));
        tbl.push_back(mk(OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0000));
        tbl.push_back(mk(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000));
        tbl.push_back(mk(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0001));
        tbl.push_back(mk(OP_DIVU,  32'd100,      32'd7,        32'd14,       4'b0000));
        tbl.push_back(mk(OP_REMU,  32'd100,      32'd7,        32'd2,        4'b0000));
        tbl.push_back(mk(OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 4'b0001));
        tbl.push_back(mk(OP_REMU,  32'd100,      32'd0,        32'd100,      4'b0000));
        tbl.push_back(mk(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b0001));
        tbl.push_back(mk(OP_REMU,  32'd7,        32'd100,      32'd7,        4'b0000));

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset F", ALU_F, 32'd0);
        chk("reset flags", 32'({ZF, CF, OF, SF}), 32'd0);

        foreach (tbl[i]) begin
            issue(tbl[i]);
            drain();
        end

        // in_ready must stay low for every BUSY cycle of a multiply
        issue(mk(OP_MUL, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0001));
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_out_valid) break;
            if (!s_in_ready) busy_cnt++;
        end
        chk("mul busy cycles", busy_cnt, 32);
        drain();

        // Backpressure hold, then back-to-back accept on release
        out_ready   = 1'b0;
        drv_chk_lat = 1'b0;
        issue(mk(OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0001));
        drv_chk_lat = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold out_valid", 32'(s_out_valid), 32'd1);
            chk("hold in_ready", 32'(s_in_ready), 32'd0);
            chk("hold F", ALU_F, 32'hF8000000);
            chk("hold flags", 32'({ZF, CF, OF, SF}), 32'b0001);
        end
        out_ready = 1'b1;
        drv       = mk(OP_XOR, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 4'b0001);
        ALU_OP    = drv.op;
        ALU_A     = drv.a;
        ALU_B     = drv.b;
        in_valid  = 1'b1;
        tick();
        chk("b2b accept", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a divide aborts it
        issue(mk(OP_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000));
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort F", ALU_F, 32'd0);
        chk("abort flags", 32'({ZF, CF, OF, SF}), 32'd0);
        for (int k = 0; k < 40; k++) tick();
        issue(mk(OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
